// File: rtl/qspi_wr_sdram_pkg.sv
// Shared definitions for the QSPI write-path to SDRAM burst writer:
// FSM encoding, default burst length and byte-to-word address conversion.
package qspi_wr_sdram_pkg;

  typedef enum logic [1:0] {
    S_IDLE,
    S_FILL,
    S_ADDR,
    S_DATA
  } wr_state_t;

  localparam int WR_BL_DEFAULT = 8;

  // QSPI addresses bytes, the SDRAM controller addresses 16-bit words
  function automatic logic [31:0] byte_to_word_addr(input logic [31:0] byte_addr);
    return byte_addr >> 1;
  endfunction

endpackage

// File: rtl/wr_burst_buf.sv
// Burst staging register file: one synchronous write port, one asynchronous
// read port, whole array cleared on reset.
module wr_burst_buf #(
  parameter int DEPTH = 8,
  parameter int DW    = 16,
  parameter int IW    = 3
) (
  input  logic          sdram_clk,
  input  logic          rst,
  input  logic          we,
  input  logic [IW-1:0] waddr,
  input  logic [DW-1:0] wdata,
  input  logic [IW-1:0] raddr,
  output logic [DW-1:0] rdata
);

  logic [DW-1:0] mem [DEPTH];

  always_ff @(posedge sdram_clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (we) begin
      mem[waddr] <= wdata;
    end
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/qspi_wr_sdram.sv
// Collects QSPI write words into WR_BL-word bursts and hands them to the
// SDRAM controller write port. Optional overflow flag: QSPI_WR_OVF_EN.
module qspi_wr_sdram
  import qspi_wr_sdram_pkg::*;
#(
  parameter int WR_BL = WR_BL_DEFAULT,
  parameter int AW    = 24,
  parameter int DW    = 16
) (
  input  logic          sdram_clk,
  input  logic          rst,
  input  logic          qspi_wr_start,
  input  logic [AW-1:0] qspi_wr_addr,
  input  logic          qspi_wr_en,
  input  logic [DW-1:0] qspi_wr_data,
  input  logic          qspi_wr_flush,
  output logic          qspi_wr_busy,
  output logic [AW-1:0] wr_addr,
  output logic [3:0]    wr_bl,
  output logic          wr_avalid,
  input  logic          wr_aready,
  output logic [DW-1:0] wr_data,
  output logic          wr_valid,
  input  logic          wr_ready
`ifdef QSPI_WR_OVF_EN
  ,
  output logic          wr_ovf
`endif
);

  localparam int         IW      = (WR_BL > 1) ? $clog2(WR_BL) : 1;
  localparam logic [3:0] BL_FULL = 4'(WR_BL);

  wr_state_t     state, state_n;
  logic [3:0]    fill_cnt, fill_n, cnt_after;
  logic [3:0]    rd_ptr, rd_n;
  logic [3:0]    bl_n;
  logic [AW-1:0] addr_n;
  logic          sess_end, end_n;
  logic          buf_we;

  wr_burst_buf #(
    .DEPTH (WR_BL),
    .DW    (DW),
    .IW    (IW)
  ) u_buf (
    .sdram_clk (sdram_clk),
    .rst       (rst),
    .we        (buf_we),
    .waddr     (fill_cnt[IW-1:0]),
    .wdata     (qspi_wr_data),
    .raddr     (rd_ptr[IW-1:0]),
    .rdata     (wr_data)
  );

  always_ff @(posedge sdram_clk) begin
    if (rst) begin
      state    <= S_IDLE;
      fill_cnt <= '0;
      rd_ptr   <= '0;
      wr_addr  <= '0;
      wr_bl    <= '0;
      sess_end <= 1'b0;
    end else begin
      state    <= state_n;
      fill_cnt <= fill_n;
      rd_ptr   <= rd_n;
      wr_addr  <= addr_n;
      wr_bl    <= bl_n;
      sess_end <= end_n;
    end
  end

  // sess_end remembers whether the burst being drained closes the session
  // (flush) or whether filling resumes at the next burst address.
  always_comb begin
    state_n   = state;
    fill_n    = fill_cnt;
    rd_n      = rd_ptr;
    addr_n    = wr_addr;
    bl_n      = wr_bl;
    end_n     = sess_end;
    buf_we    = 1'b0;
    cnt_after = fill_cnt + {3'b000, qspi_wr_en};

    case (state)
      S_IDLE: begin
        if (qspi_wr_start) begin
          addr_n  = AW'(byte_to_word_addr(32'(qspi_wr_addr)));
          fill_n  = '0;
          end_n   = 1'b0;
          state_n = S_FILL;
        end
      end
      S_FILL: begin
        buf_we = qspi_wr_en;
        fill_n = cnt_after;
        if (qspi_wr_en && (cnt_after == BL_FULL)) begin
          bl_n    = BL_FULL;
          end_n   = qspi_wr_flush;
          state_n = S_ADDR;
        end else if (qspi_wr_flush) begin
          if (cnt_after != 4'd0) begin
            bl_n    = cnt_after;
            end_n   = 1'b1;
            state_n = S_ADDR;
          end else begin
            state_n = S_IDLE;
          end
        end
      end
      S_ADDR: begin
        if (wr_aready) begin
          rd_n    = '0;
          state_n = S_DATA;
        end
      end
      S_DATA: begin
        if (wr_ready) begin
          if (rd_ptr == wr_bl - 4'd1) begin
            if (sess_end) begin
              state_n = S_IDLE;
            end else begin
              addr_n  = wr_addr + AW'(WR_BL);
              fill_n  = '0;
              state_n = S_FILL;
            end
          end else begin
            rd_n = rd_ptr + 4'd1;
          end
        end
      end
      default: state_n = S_IDLE;
    endcase
  end

  assign wr_avalid    = (state == S_ADDR);
  assign wr_valid     = (state == S_DATA);
  assign qspi_wr_busy = wr_avalid | wr_valid;

`ifdef QSPI_WR_OVF_EN
  logic ovf_q;

  // Sticky until reset: any push that the buffer could not take
  always_ff @(posedge sdram_clk) begin
    if (rst) begin
      ovf_q <= 1'b0;
    end else if (qspi_wr_en && ((state == S_IDLE) || qspi_wr_busy)) begin
      ovf_q <= 1'b1;
    end
  end

  assign wr_ovf = ovf_q;
`endif

endmodule

// File: tb/tb_qspi_wr_sdram.sv
// Directed self-checking bench for qspi_wr_sdram (default and QSPI_WR_OVF_EN builds).
module tb_qspi_wr_sdram;

  localparam int WR_BL = 8;
  localparam int AW    = 24;
  localparam int DW    = 16;

  logic          sdram_clk;
  logic          rst;
  logic          qspi_wr_start;
  logic [AW-1:0] qspi_wr_addr;
  logic          qspi_wr_en;
  logic [DW-1:0] qspi_wr_data;
  logic          qspi_wr_flush;
  logic          qspi_wr_busy;
  logic [AW-1:0] wr_addr;
  logic [3:0]    wr_bl;
  logic          wr_avalid;
  logic          wr_aready;
  logic [DW-1:0] wr_data;
  logic          wr_valid;
  logic          wr_ready;
`ifdef QSPI_WR_OVF_EN
  logic          wr_ovf;
`endif

  int checks   = 0;
  int failures = 0;

  qspi_wr_sdram #(
    .WR_BL (WR_BL),
    .AW    (AW),
    .DW    (DW)
  ) dut (
    .sdram_clk     (sdram_clk),
    .rst           (rst),
    .qspi_wr_start (qspi_wr_start),
    .qspi_wr_addr  (qspi_wr_addr),
    .qspi_wr_en    (qspi_wr_en),
    .qspi_wr_data  (qspi_wr_data),
    .qspi_wr_flush (qspi_wr_flush),
    .qspi_wr_busy  (qspi_wr_busy),
    .wr_addr       (wr_addr),
    .wr_bl         (wr_bl),
    .wr_avalid     (wr_avalid),
    .wr_aready     (wr_aready),
    .wr_data       (wr_data),
    .wr_valid      (wr_valid),
    .wr_ready      (wr_ready)
`ifdef QSPI_WR_OVF_EN
    ,
    .wr_ovf        (wr_ovf)
`endif
  );

  initial sdram_clk = 1'b0;
  always #5 sdram_clk = ~sdram_clk;

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("[TB] FAIL %s got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge sdram_clk);
    #1;
  endtask

  task automatic startSession(input logic [AW-1:0] a);
    qspi_wr_start = 1'b1;
    qspi_wr_addr  = a;
    tick();
    qspi_wr_start = 1'b0;
  endtask

  task automatic applyStimulus(input logic [DW-1:0] base, input int n);
    for (int i = 0; i < n; i++) begin
      qspi_wr_en   = 1'b1;
      qspi_wr_data = base + 16'(i);
      tick();
    end
    qspi_wr_en = 1'b0;
  endtask

  task automatic flushPulse();
    qspi_wr_flush = 1'b1;
    tick();
    qspi_wr_flush = 1'b0;
  endtask

  task automatic pushFlush(input logic [DW-1:0] d);
    qspi_wr_en    = 1'b1;
    qspi_wr_data  = d;
    qspi_wr_flush = 1'b1;
    tick();
    qspi_wr_en    = 1'b0;
    qspi_wr_flush = 1'b0;
  endtask

  // Waits for the address phase, optionally stalls it, then drains the words
  // with ready held or toggling, optionally pushing a word mid-burst.
  task automatic drainBurst(input string tag, input logic [AW-1:0] ea, input logic [3:0] ebl,
                            input logic [DW-1:0] base, input int a_delay, input bit toggle,
                            input bit inject);
    int budget;
    int idx;
    int cyc;
    budget = 0;
    while (!wr_avalid && budget < 20) begin
      tick();
      budget++;
    end
    checkOutput({tag, "_avalid"}, 32'(wr_avalid), 32'd1);
    if (!wr_avalid) return;
    checkOutput({tag, "_busy"}, 32'(qspi_wr_busy), 32'd1);
    checkOutput({tag, "_addr"}, 32'(wr_addr), 32'(ea));
    checkOutput({tag, "_bl"}, 32'(wr_bl), 32'(ebl));
    for (int d = 0; d < a_delay; d++) begin
      tick();
      checkOutput({tag, "_addr_hold"}, 32'(wr_addr), 32'(ea));
      checkOutput({tag, "_avalid_hold"}, 32'(wr_avalid), 32'd1);
    end
    wr_aready = 1'b1;
    tick();
    wr_aready = 1'b0;
    checkOutput({tag, "_valid"}, 32'(wr_valid), 32'd1);
    idx = 0;
    cyc = 0;
    while (idx < int'(ebl) && cyc < 64) begin
      wr_ready = toggle ? (cyc % 2 == 1) : 1'b1;
      if (inject && cyc == 0) begin
        wr_ready     = 1'b0;
        qspi_wr_en   = 1'b1;
        qspi_wr_data = 16'hDEAD;
      end
      checkOutput({tag, "_data"}, 32'(wr_data), 32'(base + 16'(idx)));
      tick();
      qspi_wr_en = 1'b0;
      if (wr_ready) idx++;
      cyc++;
    end
    wr_ready = 1'b0;
    checkOutput({tag, "_words"}, 32'(idx), 32'(ebl));
    checkOutput({tag, "_valid_end"}, 32'(wr_valid), 32'd0);
    checkOutput({tag, "_busy_end"}, 32'(qspi_wr_busy), 32'd0);
  endtask

  // A push+flush that produces no address phase proves the FSM sits in S_IDLE
  task automatic checkIdle(input string tag);
    applyStimulus(16'h1111, 1);
    flushPulse();
    tick();
    tick();
    checkOutput({tag, "_idle"}, 32'(wr_avalid), 32'd0);
  endtask

  initial begin
    rst           = 1'b1;
    qspi_wr_start = 1'b0;
    qspi_wr_addr  = '0;
    qspi_wr_en    = 1'b0;
    qspi_wr_data  = '0;
    qspi_wr_flush = 1'b0;
    wr_aready     = 1'b0;
    wr_ready      = 1'b0;
    tick();
    tick();
    checkOutput("rst_avalid", 32'(wr_avalid), 32'd0);
    checkOutput("rst_valid", 32'(wr_valid), 32'd0);
    checkOutput("rst_busy", 32'(qspi_wr_busy), 32'd0);
    checkOutput("rst_addr", 32'(wr_addr), 32'd0);
    checkOutput("rst_bl", 32'(wr_bl), 32'd0);
    checkOutput("rst_data", 32'(wr_data), 32'd0);
`ifdef QSPI_WR_OVF_EN
    checkOutput("rst_ovf", 32'(wr_ovf), 32'd0);
`endif
    rst = 1'b0;
    tick();

    // One full burst, address phase the cycle after the eighth push
    startSession(24'h000010);
    applyStimulus(16'hA000, 8);
    checkOutput("t1_avalid_k1", 32'(wr_avalid), 32'd1);
    drainBurst("t1", 24'h000008, 4'd8, 16'hA000, 0, 1'b0, 1'b0);
    flushPulse();
    checkIdle("t1");

    // Eleven words then flush: full burst, then a 3-word burst at the next address
    startSession(24'h000010);
    applyStimulus(16'hB000, 8);
    drainBurst("t2a", 24'h000008, 4'd8, 16'hB000, 0, 1'b0, 1'b0);
    applyStimulus(16'hB008, 3);
    flushPulse();
    drainBurst("t2b", 24'h000010, 4'd3, 16'hB008, 0, 1'b0, 1'b0);
    checkIdle("t2");

    // Stalled address phase, toggling ready, and a dropped push during S_DATA
    startSession(24'h000100);
    applyStimulus(16'hC000, 8);
    drainBurst("t3", 24'h000080, 4'd8, 16'hC000, 5, 1'b1, 1'b1);
    flushPulse();
    tick();
    checkOutput("t3_drop_not_counted", 32'(wr_avalid), 32'd0);
`ifdef QSPI_WR_OVF_EN
    checkOutput("t3_ovf", 32'(wr_ovf), 32'd1);
`endif

    // High start address: word address 0x7FFFF8, next burst +8
    startSession(24'hFFFFF0);
    applyStimulus(16'hD000, 8);
    drainBurst("t4a", 24'h7FFFF8, 4'd8, 16'hD000, 0, 1'b0, 1'b0);
    applyStimulus(16'hD008, 8);
    drainBurst("t4b", 24'h800000, 4'd8, 16'hD008, 0, 1'b0, 1'b0);
    flushPulse();

    // Push and flush together on the last slot: full burst, session ends
    startSession(24'h000040);
    applyStimulus(16'hE000, 7);
    pushFlush(16'hE007);
    drainBurst("t5", 24'h000020, 4'd8, 16'hE000, 0, 1'b0, 1'b0);
    checkIdle("t5");

    // Flush counting the word pushed in the same cycle
    startSession(24'h000080);
    applyStimulus(16'hF000, 2);
    pushFlush(16'hF002);
    drainBurst("t6", 24'h000040, 4'd3, 16'hF000, 0, 1'b0, 1'b0);
    checkIdle("t6");

    // Reset in the middle of the data phase
    startSession(24'h000200);
    applyStimulus(16'h9000, 8);
    checkOutput("t7_avalid", 32'(wr_avalid), 32'd1);
    wr_aready = 1'b1;
    tick();
    wr_aready = 1'b0;
    wr_ready  = 1'b1;
    tick();
    tick();
    tick();
    checkOutput("t7_mid_valid", 32'(wr_valid), 32'd1);
    checkOutput("t7_mid_data", 32'(wr_data), 32'h9003);
    rst      = 1'b1;
    wr_ready = 1'b0;
    tick();
    checkOutput("t7_rst_valid", 32'(wr_valid), 32'd0);
    checkOutput("t7_rst_busy", 32'(qspi_wr_busy), 32'd0);
    checkOutput("t7_rst_addr", 32'(wr_addr), 32'd0);
    checkOutput("t7_rst_avalid", 32'(wr_avalid), 32'd0);
    checkOutput("t7_rst_bl", 32'(wr_bl), 32'd0);
    checkOutput("t7_rst_data", 32'(wr_data), 32'd0);
    rst = 1'b0;
    tick();
    tick();
    checkOutput("t7_post_avalid", 32'(wr_avalid), 32'd0);
    checkOutput("t7_post_valid", 32'(wr_valid), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
